// File: rtl/bin_to_digit_encoder.sv
// Sequential double-dabble binary-to-BCD encoder feeding seven-segment digit decoders.
// Optional build macro LEAD_BLANK_EN replaces leading zero digits with the blank code.
module bin_to_digit_encoder #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   digits
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_q,    state_d;
  logic [BIN_W-1:0]   shift_q,    shift_d;
  logic [BCD_W-1:0]   bcd_q,      bcd_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic               ovf_next_q, ovf_next_d;
  logic               busy_q,     busy_d;
  logic               done_q,     done_d;
  logic               ovf_q,      ovf_d;
  logic [BCD_W-1:0]   digits_q,   digits_d;

  // Adds 3 to every nibble that is 5 or more, ahead of the shift.
  function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

`ifdef LEAD_BLANK_EN
  // Blanks the run of zero digits from the top down; digit 0 is always shown.
  function automatic logic [BCD_W-1:0] blank_lead(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             lead;
    r    = v;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (v[4*i +: 4] == 4'h0)) begin
        r[4*i +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction
`endif

  // Next-state and datapath logic for the three-state conversion FSM.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_next_d = ovf_next_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shift_d    = bin;
          bcd_d      = '0;
          cnt_d      = CNT_W'(BIN_W);
          busy_d     = 1'b1;
          ovf_next_d = (64'(bin) > MAX_VAL);
          state_d    = ST_SHIFT;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // Carries out of the top nibble fall off; ovf covers that range.
        {bcd_d, shift_d} = {add3_all(bcd_q), shift_q} << 1;
        cnt_d            = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (ovf_next_q) begin
          digits_d = {DIGITS{4'hA}};
        end else begin
`ifdef LEAD_BLANK_EN
          digits_d = blank_lead(bcd_q);
`else
          digits_d = bcd_q;
`endif
        end
        ovf_d   = ovf_next_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      ovf_next_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      digits_q   <= {DIGITS{4'hF}};
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      ovf_next_q <= ovf_next_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
      digits_q   <= digits_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign ovf    = ovf_q;
  assign digits = digits_q;

endmodule

// File: tb/tb_bin_to_digit_encoder.sv
// Self-checking bench for bin_to_digit_encoder (BIN_W=10, DIGITS=3) against a decimal reference model.
module tb_bin_to_digit_encoder;

  localparam int BIN_W  = 10;
  localparam int DIGITS = 3;
  localparam int LAT    = BIN_W + 1;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                busy;
  logic                done;
  logic                ovf;
  logic [4*DIGITS-1:0] digits;

  int checks   = 0;
  int failures = 0;

  bin_to_digit_encoder #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bin    (bin),
    .busy   (busy),
    .done   (done),
    .ovf    (ovf),
    .digits (digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits by division, overflow by comparison against 10^DIGITS-1.
  function automatic logic [4*DIGITS-1:0] model_digits(input int v);
    logic [4*DIGITS-1:0] r;
    int                  rest;
    int                  top;
    if (v > 999) return {DIGITS{4'hA}};
    rest = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(rest % 10);
      rest = rest / 10;
    end
`ifdef LEAD_BLANK_EN
    top = (v >= 100) ? 2 : (v >= 10) ? 1 : 0;
    for (int i = 1; i < DIGITS; i++)
      if (i > top) r[4*i +: 4] = 4'hF;
`else
    top = 0;
`endif
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for done (bounded), returns edges counted after the accept edge; busy must stay high until then.
  task automatic wait_done(input string tag, output int n);
    logic busy_bad;
    busy_bad = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_bad = 1'b1;
    end
    check($sformatf("%s_busy_span", tag), {31'd0, busy_bad}, 32'd0);
    check($sformatf("%s_latency", tag), n, LAT);
  endtask

  task automatic convert(input int v, input string tag);
    int                  n;
    logic [4*DIGITS-1:0] prev;
    @(negedge clk);
    bin   = 10'(v);
    start = 1'b1;
    prev  = digits;
    @(posedge clk); #1;
    start = 1'b0;
    check($sformatf("%s_busy_acc", tag), {31'd0, busy}, 32'd1);
    wait_done(tag, n);
    check($sformatf("%s_digits", tag), 32'(digits), 32'(model_digits(v)));
    check($sformatf("%s_ovf", tag), {31'd0, ovf}, {31'd0, (v > 999)});
    check($sformatf("%s_busy_done", tag), {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    check($sformatf("%s_done_pulse", tag), {31'd0, done}, 32'd0);
    check($sformatf("%s_hold", tag), 32'(digits), 32'(model_digits(v)));
    if (prev === 12'hFFF) begin
      check($sformatf("%s_prev", tag), 32'(prev), 32'hFFF);
    end else begin
      check($sformatf("%s_prev_known", tag), {31'd0, ^prev === 1'bx}, 32'd0);
    end
  endtask

  initial begin
    int n;
    int v;
    logic saw_done;
    rst_n = 1'b1;
    start = 1'b0;
    bin   = '0;

    // Asynchronous reset, checked before any clock edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy",   {31'd0, busy}, 32'd0);
    check("rst_done",   {31'd0, done}, 32'd0);
    check("rst_ovf",    {31'd0, ovf},  32'd0);
    check("rst_digits", 32'(digits),   32'hFFF);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    convert(937,  "basic937");
    convert(5,    "five");
    convert(0,    "zero");
    convert(999,  "b999");
    convert(1000, "b1000");
    convert(1023, "b1023");
    convert(42,   "after_ovf42");

    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 1023));
      convert(v, $sformatf("rand%0d_%0d", i, v));
    end

    // start held high; bin changes three cycles after the first accept.
    @(negedge clk);
    bin   = 10'd456;
    start = 1'b1;
    @(posedge clk); #1;
    check("held_busy_acc", {31'd0, busy}, 32'd1);
    repeat (3) @(posedge clk);
    #1 bin = 10'd123;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) break;
    end
    check("held_first_latency", n, LAT - 3);
    check("held_first_digits", 32'(digits), 32'(model_digits(456)));
    @(posedge clk); #1;
    start = 1'b0;
    check("held_second_acc", {31'd0, busy}, 32'd1);
    wait_done("held_second", n);
    check("held_period", n + 1, BIN_W + 2);
    check("held_second_digits", 32'(digits), 32'(model_digits(123)));

    // Reset mid-conversion: immediate abort, no done afterwards.
    @(negedge clk);
    bin   = 10'd777;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy",   {31'd0, busy}, 32'd0);
    check("midrst_done",   {31'd0, done}, 32'd0);
    check("midrst_ovf",    {31'd0, ovf},  32'd0);
    check("midrst_digits", 32'(digits),   32'hFFF);
    saw_done = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done === 1'b1) saw_done = 1'b1;
    end
    check("midrst_no_done", {31'd0, saw_done}, 32'd0);
    check("midrst_digits_after", 32'(digits), 32'hFFF);
    convert(777, "after_rst777");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
